halton_stream_sched: RTL and testbench
======================================

// Module: halton_stream_sched
// PURPOSE
//  Round-robin scheduler sharing one Halton base-3 low-discrepancy generator among NUM_REQ requesters.
//  Per granted request: loads the requester's seed into the generator, discards pipeline-warmup samples,
//  then emits a stochastic bitstream of stream_len bits (bit = gen_value < req_value) plus a ones count.
//  Sits between the SC operand producers and the shared generator instance; one stream in flight at a time.
// PARAMETERS
//  NUM_REQ   4   number of requesters (2..8)
//  ID_W      2   requester index width, >= clog2(NUM_REQ)
//  LEN_W     16  stream length / ones-count width
//  GEN_LAT   2   cycles from gen_load deassertion to first valid gen_value for the loaded seed
// PORTS
//  clk          in   1             rising-edge clock
//  reset_n      in   1             asynchronous, active-low reset
//  req_valid    in   NUM_REQ       per-requester request pending
//  req_value    in   NUM_REQ*24    per-requester target probability, unsigned Q0.24, slice i = [24i+23:24i]
//  req_seed     in   NUM_REQ*32    per-requester generator seed, slice i = [32i+31:32i]
//  req_ready    out  NUM_REQ       one-hot grant; request i accepted when req_valid[i] & req_ready[i]
//  stream_len   in   LEN_W         bits per stream, sampled in the grant cycle
//  abort        in   1             synchronous cancel of the stream in flight
//  gen_load     out  1             drives generator reset/load input (active-high, synchronous)
//  gen_seed     out  32            seed presented to generator
//  gen_value    in   24            generator output sample
//  bit_valid    out  1             bit_out valid this cycle (no backpressure)
//  bit_out      out  1             stochastic bit
//  bit_id       out  ID_W          requester owning the current stream
//  bit_last     out  1             final bit of the stream
//  done         out  1             one-cycle pulse: stream completed, ones_cnt valid
//  ones_cnt     out  LEN_W         number of 1 bits emitted in the completed stream
//  busy         out  1             high in every state except IDLE
// BEHAVIOUR
//  Reset (async, reset_n=0): state IDLE, rr pointer 0, all outputs 0 except gen_load=1 (generator held).
//  FSM: IDLE -> LOAD -> WARM -> STREAM -> DONE -> IDLE. All outputs registered except req_ready.
//  IDLE: gen_load=1. If any req_valid: pick first set index at or after rr pointer (wrapping);
//   req_ready[i]=1 combinationally this cycle only; latch value, seed, stream_len, id=i; rr <= i+1 mod NUM_REQ;
//   -> LOAD. req_ready is 0 in all other states.
//  LOAD: 1 cycle, gen_load=1, gen_seed=latched seed. -> WARM.
//  WARM: gen_load=0 for exactly GEN_LAT cycles, samples discarded. -> STREAM, or -> DONE if latched len=0.
//  STREAM: len cycles; each cycle bit_valid=1, bit_out=(gen_value < value) unsigned 24-bit compare,
//   bit_id=id, ones counter += bit_out; bit_last=1 on the len-th bit. -> DONE after last bit.
//  DONE: done=1 one cycle, ones_cnt=final count (held until next done), busy=1. -> IDLE (re-arbitrate next cycle).
//  Grant-to-first-bit latency: grant cycle G, first bit at G+2+GEN_LAT; done at G+2+GEN_LAT+len.
//  Boundaries: value=0 -> all bits 0; len=0 -> no bit_valid, done with ones_cnt=0; len=2^LEN_W-1 legal;
//   ones counter cannot overflow (<= len). Requests arriving mid-stream wait; req_valid deassert while
//   waiting is legal (no grant). Latched operands are immune to req_* changes after grant.
//  abort=1 in LOAD/WARM/STREAM/DONE: next state IDLE, bit_valid/bit_last/done forced 0 that cycle onward,
//   ones_cnt unchanged, rr pointer keeps its post-grant value. abort in IDLE ignored; abort wins over done.
//  Async reset mid-stream: immediate return to reset values; no done.
// TESTING
//  1. req_valid=4'b0001, value=24'h800000, seed=0, len=8, GEN_LAT=2 with real generator -> req_ready[0]
//     at G, bits at G+4..G+11, bit_last at G+11, done at G+12, ones_cnt = count of samples < 0x800000.
//  2. req_valid=4'b1011 held from reset -> grants in order 0,1,3,0; bit_id matches each stream; no overlap.
//  3. value=0, len=16 -> 16 bits all 0, ones_cnt=0; value=24'hFFFFFF, generator stub constant 0 -> ones_cnt=16.
//  4. len=0 -> no bit_valid, done at G+2+GEN_LAT, ones_cnt=0, busy falls next cycle.
//  5. abort on 3rd STREAM bit of len=10 -> bit_valid low next cycle, no done, state IDLE, next grant normal.
//  6. reset_n low for 1 cycle mid-WARM -> all outputs to reset values asynchronously, gen_load=1, rr=0.

Source files
------------

// File: rtl/halton_stream_sched.sv
// rtl/halton_stream_sched.sv - round-robin scheduler sharing one Halton generator among requesters.
// Each grant loads a seed, skips the generator warmup and emits a stochastic bitstream plus a ones count.
module halton_stream_sched #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int LEN_W   = 16,
  parameter int GEN_LAT = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*24-1:0] req_value,
  input  logic [NUM_REQ*32-1:0] req_seed,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [LEN_W-1:0]      stream_len,
  input  logic                  abort,
  output logic                  gen_load,
  output logic [31:0]           gen_seed,
  input  logic [23:0]           gen_value,
  output logic                  bit_valid,
  output logic                  bit_out,
  output logic [ID_W-1:0]       bit_id,
  output logic                  bit_last,
  output logic                  done,
  output logic [LEN_W-1:0]      ones_cnt,
  output logic                  busy
);

  localparam int WARM_W = (GEN_LAT > 1) ? $clog2(GEN_LAT) : 1;
  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(GEN_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_WARM   = 3'd2,
    S_STREAM = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t            state_q;
  logic [ID_W-1:0]   rr_q, rr_d, id_q;
  logic [23:0]       value_q;
  logic [LEN_W-1:0]  len_q, rem_q, ones_q, ones_d, ones_cnt_q;
  logic [WARM_W-1:0] warm_q;
  logic [31:0]       gen_seed_q;
  logic              gen_load_q, bit_valid_q, bit_last_q, done_q, busy_q;
  logic              grant_any;
  logic [ID_W-1:0]   grant_idx;

  // Scan downward so the lowest offset from the rr pointer is the last one written.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[(int'(rr_q) + k) % NUM_REQ]) begin
        grant_any = 1'b1;
        grant_idx = ID_W'((int'(rr_q) + k) % NUM_REQ);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (reset_n && state_q == S_IDLE && grant_any) req_ready[grant_idx] = 1'b1;
  end

  assign rr_d   = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
  assign ones_d = ones_q + LEN_W'(bit_out);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      rr_q        <= '0;
      id_q        <= '0;
      value_q     <= '0;
      len_q       <= '0;
      rem_q       <= '0;
      warm_q      <= '0;
      ones_q      <= '0;
      ones_cnt_q  <= '0;
      gen_seed_q  <= '0;
      gen_load_q  <= 1'b1;
      bit_valid_q <= 1'b0;
      bit_last_q  <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      bit_valid_q <= 1'b0;
      bit_last_q  <= 1'b0;
      done_q      <= 1'b0;
      if (abort && state_q != S_IDLE) begin
        state_q    <= S_IDLE;
        gen_load_q <= 1'b1;
        busy_q     <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: if (grant_any) begin
            state_q    <= S_LOAD;
            id_q       <= grant_idx;
            rr_q       <= rr_d;
            value_q    <= req_value[int'(grant_idx)*24 +: 24];
            gen_seed_q <= req_seed[int'(grant_idx)*32 +: 32];
            len_q      <= stream_len;
            gen_load_q <= 1'b1;
            busy_q     <= 1'b1;
          end
          S_LOAD: begin
            state_q    <= S_WARM;
            gen_load_q <= 1'b0;
            warm_q     <= '0;
          end
          S_WARM: begin
            if (warm_q != WARM_LAST) begin
              warm_q <= warm_q + WARM_W'(1);
            end else if (len_q == '0) begin
              state_q    <= S_DONE;
              done_q     <= 1'b1;
              ones_cnt_q <= '0;
              gen_load_q <= 1'b1;
            end else begin
              state_q     <= S_STREAM;
              bit_valid_q <= 1'b1;
              bit_last_q  <= (len_q == LEN_W'(1));
              rem_q       <= len_q - LEN_W'(1);
              ones_q      <= '0;
            end
          end
          // rem_q counts bits still to come after the one on the output this cycle.
          S_STREAM: begin
            if (rem_q == '0) begin
              state_q    <= S_DONE;
              done_q     <= 1'b1;
              ones_cnt_q <= ones_d;
              gen_load_q <= 1'b1;
            end else begin
              bit_valid_q <= 1'b1;
              bit_last_q  <= (rem_q == LEN_W'(1));
              rem_q       <= rem_q - LEN_W'(1);
              ones_q      <= ones_d;
            end
          end
          S_DONE: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign gen_load  = gen_load_q;
  assign gen_seed  = gen_seed_q;
  assign bit_valid = bit_valid_q;
  assign bit_out   = bit_valid_q & (gen_value < value_q);
  assign bit_id    = id_q;
  assign bit_last  = bit_last_q;
  assign done      = done_q;
  assign ones_cnt  = ones_cnt_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_halton_stream_sched.sv
// tb/tb_halton_stream_sched.sv - directed bench for halton_stream_sched with a Halton base-3 generator stub.
module tb_halton_stream_sched;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int LEN_W   = 16;
  localparam int GEN_LAT = 2;

  logic                  clk = 1'b0;
  logic                  reset_n = 1'b0;
  logic [NUM_REQ-1:0]    req_valid = '0;
  logic [NUM_REQ*24-1:0] req_value = '0;
  logic [NUM_REQ*32-1:0] req_seed = '0;
  logic [NUM_REQ-1:0]    req_ready;
  logic [LEN_W-1:0]      stream_len = '0;
  logic                  abort = 1'b0;
  logic                  gen_load;
  logic [31:0]           gen_seed;
  logic [23:0]           gen_value;
  logic                  bit_valid, bit_out, bit_last, done, busy;
  logic [ID_W-1:0]       bit_id;
  logic [LEN_W-1:0]      ones_cnt;

  logic        gen_const_mode = 1'b0;
  logic [23:0] gen_const = '0;
  int unsigned k_q = 0;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  halton_stream_sched #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .LEN_W(LEN_W), .GEN_LAT(GEN_LAT)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_value(req_value),
    .req_seed(req_seed), .req_ready(req_ready), .stream_len(stream_len), .abort(abort),
    .gen_load(gen_load), .gen_seed(gen_seed), .gen_value(gen_value), .bit_valid(bit_valid),
    .bit_out(bit_out), .bit_id(bit_id), .bit_last(bit_last), .done(done),
    .ones_cnt(ones_cnt), .busy(busy)
  );

  function automatic logic [23:0] halton3(input longint unsigned n_in);
    real x, f;
    longint unsigned n;
    x = 0.0;
    f = 1.0 / 3.0;
    n = n_in;
    while (n != 0) begin
      x = x + f * real'(n % 3);
      n = n / 3;
      f = f / 3.0;
    end
    return 24'(longint'(x * 16777216.0));
  endfunction

  // Generator stub: zero while warming up, then Halton(seed + sample index) GEN_LAT cycles after load drops.
  always @(posedge clk) begin
    if (gen_load) k_q <= 0;
    else          k_q <= k_q + 1;
  end
  assign gen_value = gen_const_mode ? gen_const :
                     (k_q >= 2) ? halton3(64'(gen_seed) + 64'(k_q) - 64'd2) : 24'h0;

  task automatic run_stream(input int r, input int ncyc, output int g, output int fb, output int lb,
                            output int dn, output int bz, output int nb, output logic [31:0] bits,
                            output logic [LEN_W-1:0] oc, output int idbad);
    g = -1; fb = -1; lb = -1; dn = -1; bz = -1; nb = 0; bits = '0; oc = '0; idbad = 0;
    req_valid[r] = 1'b1;
    for (int c = 0; c < ncyc; c++) begin
      if (c == 0) #1;
      else @(negedge clk);
      if (g >= 0 && c == g + 1) req_valid[r] = 1'b0;
      if (g < 0 && req_ready[r]) g = c;
      if (bit_valid) begin
        if (fb < 0) fb = c;
        if (nb < 32) bits[nb] = bit_out;
        nb++;
        if (bit_id !== ID_W'(r)) idbad++;
      end
      if (bit_last) lb = c;
      if (done && dn < 0) begin dn = c; oc = ones_cnt; end
      if (dn >= 0 && bz < 0 && !busy) bz = c;
    end
    req_valid[r] = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req_valid = 4'b1011; abort = 1'b0;
    @(negedge clk);
    total++; if (gen_load !== 1'b1) begin bad++; $display("FAIL reset_gen_load got=%b exp=1", gen_load); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
    total++; if ({bit_valid, bit_out, bit_last, done} !== 4'b0000) begin bad++; $display("FAIL reset_bits got=%b exp=0000", {bit_valid, bit_out, bit_last, done}); end
    total++; if (ones_cnt !== 16'd0 || gen_seed !== 32'd0 || bit_id !== 2'd0) begin bad++; $display("FAIL reset_regs ones=%0d seed=%h id=%0d exp=0", ones_cnt, gen_seed, bit_id); end
  endtask

  task automatic test_round_robin();
    int gr[8];
    logic [LEN_W-1:0] oc[8];
    int exp_g[4] = '{0, 1, 3, 0};
    int exp_o[4] = '{3, 0, 3, 3};
    int ngr, dn_n, cur, gi, idbad, ovl, clr_at;
    gen_const_mode = 1'b1; gen_const = 24'h0; stream_len = 16'd3;
    req_value = {24'hFFFFFF, 24'h0, 24'h0, 24'hFFFFFF};
    reset_n = 1'b0; req_valid = 4'b1011;
    @(negedge clk);
    reset_n = 1'b1;
    ngr = 0; dn_n = 0; cur = 0; idbad = 0; ovl = 0; clr_at = -1;
    for (int i = 0; i < 8; i++) begin gr[i] = -1; oc[i] = '0; end
    for (int c = 0; c < 100; c++) begin
      if (c == 0) #1;
      else @(negedge clk);
      if (c == clr_at) req_valid = '0;
      if (req_ready != '0) begin
        if (busy) ovl++;
        gi = 9;
        for (int i = 0; i < 4; i++) if (req_ready == 4'(1 << i)) gi = i;
        if (ngr < 8) gr[ngr] = gi;
        cur = gi; ngr++;
        if (ngr == 4) clr_at = c + 1;
      end
      if (bit_valid && bit_id !== ID_W'(cur)) idbad++;
      if (done) begin if (dn_n < 8) oc[dn_n] = ones_cnt; dn_n++; end
    end
    total++; if (ngr !== 4) begin bad++; $display("FAIL rr_grant_count got=%0d exp=4", ngr); end
    for (int i = 0; i < 4; i++) begin
      total++; if (gr[i] !== exp_g[i]) begin bad++; $display("FAIL rr_grant_order idx=%0d got=%0d exp=%0d", i, gr[i], exp_g[i]); end
      total++; if (oc[i] !== LEN_W'(exp_o[i])) begin bad++; $display("FAIL rr_ones idx=%0d got=%0d exp=%0d", i, oc[i], exp_o[i]); end
    end
    total++; if (ovl !== 0) begin bad++; $display("FAIL rr_overlap got=%0d exp=0", ovl); end
    total++; if (idbad !== 0) begin bad++; $display("FAIL rr_bit_id got=%0d exp=0", idbad); end
    total++; if (dn_n !== 4) begin bad++; $display("FAIL rr_done_count got=%0d exp=4", dn_n); end
  endtask

  task automatic test_single_stream();
    int g, fb, lb, dn, bz, nb, idbad;
    logic [31:0] bits;
    logic [LEN_W-1:0] oc;
    gen_const_mode = 1'b0; stream_len = 16'd8;
    req_value[0 +: 24] = 24'h800000; req_seed[0 +: 32] = 32'd0;
    run_stream(0, 30, g, fb, lb, dn, bz, nb, bits, oc, idbad);
    total++; if (g !== 0) begin bad++; $display("FAIL t1_grant got=%0d exp=0", g); end
    total++; if (fb !== g + 4) begin bad++; $display("FAIL t1_first_bit got=%0d exp=%0d", fb, g + 4); end
    total++; if (lb !== g + 11) begin bad++; $display("FAIL t1_bit_last got=%0d exp=%0d", lb, g + 11); end
    total++; if (dn !== g + 12) begin bad++; $display("FAIL t1_done got=%0d exp=%0d", dn, g + 12); end
    total++; if (nb !== 8) begin bad++; $display("FAIL t1_nbits got=%0d exp=8", nb); end
    total++; if (bits[7:0] !== 8'h5B) begin bad++; $display("FAIL t1_bits got=%h exp=5b", bits[7:0]); end
    total++; if (oc !== 16'd5) begin bad++; $display("FAIL t1_ones got=%0d exp=5", oc); end
    total++; if (idbad !== 0) begin bad++; $display("FAIL t1_bit_id got=%0d exp=0", idbad); end
  endtask

  task automatic test_value_extremes();
    int g, fb, lb, dn, bz, nb, idbad;
    logic [31:0] bits;
    logic [LEN_W-1:0] oc;
    gen_const_mode = 1'b0; stream_len = 16'd16;
    req_value[2*24 +: 24] = 24'h0; req_seed[2*32 +: 32] = 32'd5;
    run_stream(2, 40, g, fb, lb, dn, bz, nb, bits, oc, idbad);
    total++; if (nb !== 16) begin bad++; $display("FAIL t3_zero_nbits got=%0d exp=16", nb); end
    total++; if (bits[15:0] !== 16'h0000) begin bad++; $display("FAIL t3_zero_bits got=%h exp=0000", bits[15:0]); end
    total++; if (oc !== 16'd0) begin bad++; $display("FAIL t3_zero_ones got=%0d exp=0", oc); end
    total++; if (dn !== g + 20) begin bad++; $display("FAIL t3_zero_done got=%0d exp=%0d", dn, g + 20); end
    gen_const_mode = 1'b1; gen_const = 24'h0;
    req_value[2*24 +: 24] = 24'hFFFFFF;
    run_stream(2, 40, g, fb, lb, dn, bz, nb, bits, oc, idbad);
    total++; if (bits[15:0] !== 16'hFFFF) begin bad++; $display("FAIL t3_full_bits got=%h exp=ffff", bits[15:0]); end
    total++; if (oc !== 16'd16) begin bad++; $display("FAIL t3_full_ones got=%0d exp=16", oc); end
    total++; if (idbad !== 0) begin bad++; $display("FAIL t3_bit_id got=%0d exp=0", idbad); end
  endtask

  task automatic test_len_zero();
    int g, fb, lb, dn, bz, nb, idbad;
    logic [31:0] bits;
    logic [LEN_W-1:0] oc;
    gen_const_mode = 1'b1; gen_const = 24'h0; stream_len = 16'd0;
    req_value[1*24 +: 24] = 24'hFFFFFF;
    run_stream(1, 20, g, fb, lb, dn, bz, nb, bits, oc, idbad);
    total++; if (nb !== 0 || fb !== -1) begin bad++; $display("FAIL t4_no_bits got=%0d exp=0", nb); end
    total++; if (dn !== g + 4) begin bad++; $display("FAIL t4_done got=%0d exp=%0d", dn, g + 4); end
    total++; if (oc !== 16'd0) begin bad++; $display("FAIL t4_ones got=%0d exp=0", oc); end
    total++; if (bz !== g + 5) begin bad++; $display("FAIL t4_busy_fall got=%0d exp=%0d", bz, g + 5); end
  endtask

  task automatic test_abort();
    int g, fb, lb, dn, bz, nb, idbad, seen, dcnt, vcnt;
    logic [31:0] bits;
    logic [LEN_W-1:0] oc;
    gen_const_mode = 1'b1; gen_const = 24'h0; stream_len = 16'd10;
    req_value[3*24 +: 24] = 24'hFFFFFF; req_seed[3*32 +: 32] = 32'hDEADBEEF;
    req_valid[3] = 1'b1;
    #1;
    total++; if (req_ready !== 4'b1000) begin bad++; $display("FAIL t5_grant got=%b exp=1000", req_ready); end
    @(negedge clk);
    req_valid = '0;
    total++; if (gen_load !== 1'b1 || gen_seed !== 32'hDEADBEEF) begin bad++; $display("FAIL t5_load got=%b/%h exp=1/deadbeef", gen_load, gen_seed); end
    seen = 0;
    for (int c = 0; c < 20 && seen < 3; c++) begin
      @(negedge clk);
      if (bit_valid) seen++;
    end
    total++; if (seen !== 3) begin bad++; $display("FAIL t5_reach_bit3 got=%0d exp=3", seen); end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    total++; if (bit_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL t5_abort_stop got=%b%b exp=00", bit_valid, busy); end
    dcnt = 0; vcnt = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (done) dcnt++;
      if (bit_valid) vcnt++;
    end
    total++; if (dcnt !== 0 || vcnt !== 0) begin bad++; $display("FAIL t5_quiet got=%0d/%0d exp=0/0", dcnt, vcnt); end
    total++; if (ones_cnt !== 16'd0) begin bad++; $display("FAIL t5_ones_kept got=%0d exp=0", ones_cnt); end
    stream_len = 16'd3;
    req_value[2*24 +: 24] = 24'hFFFFFF;
    run_stream(2, 20, g, fb, lb, dn, bz, nb, bits, oc, idbad);
    total++; if (g !== 0 || nb !== 3 || oc !== 16'd3) begin bad++; $display("FAIL t5_next_grant got=%0d/%0d/%0d exp=0/3/3", g, nb, oc); end
  endtask

  task automatic test_reset_mid_warm();
    int dcnt;
    gen_const_mode = 1'b1; gen_const = 24'h0; stream_len = 16'd4;
    req_seed[2*32 +: 32] = 32'h12345678;
    req_valid[2] = 1'b1;
    #1;
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    total++; if (gen_load !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL t6_in_warm got=%b%b exp=01", gen_load, busy); end
    reset_n = 1'b0;
    #1;
    total++; if (gen_load !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL t6_async got=%b%b exp=10", gen_load, busy); end
    total++; if (ones_cnt !== 16'd0 || gen_seed !== 32'd0 || {bit_valid, done} !== 2'b00) begin bad++; $display("FAIL t6_regs ones=%0d seed=%h vd=%b exp=0", ones_cnt, gen_seed, {bit_valid, done}); end
    @(negedge clk);
    reset_n = 1'b1;
    dcnt = 0;
    for (int c = 0; c < 8; c++) begin @(negedge clk); if (done) dcnt++; end
    total++; if (dcnt !== 0) begin bad++; $display("FAIL t6_no_done got=%0d exp=0", dcnt); end
    req_valid = 4'b1111;
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL t6_rr_reset got=%b exp=0001", req_ready); end
    @(negedge clk);
    req_valid = '0;
    repeat (12) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single_stream();
    test_value_extremes();
    test_len_zero();
    test_abort();
    test_reset_mid_warm();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
